pipeline_hazard_controller: RTL and testbench
=============================================

// Module: pipeline_hazard_controller
// PURPOSE
// Decode-stage hazard/stall controller. Feeds the forwarding units: it stalls only for hazards they cannot cover.
//  - load-use into the EX ALU
//  - branch/jump operands still in flight for the ID-stage branch ALU
//  - a multi-cycle divide occupying EX
// Drives PC/IF-ID hold, ID-EX bubble insertion, EX hold, and IF-ID flush on taken branches.
// PARAMETERS
// DIV_LATENCY  8   total cycles a divide occupies EX, including its first cycle (legal 2..255)
// STAT_WIDTH   32  width of stall_cycles counter (only with HAZARD_STATS_EN)
// PORTS
// clk           in   1   core clock
// rst           in   1   asynchronous reset, active-high
// ID_Rs1        in   5   rs1 of instruction in ID
// ID_Rs2        in   5   rs2 of instruction in ID
// ID_UsesRs1    in   1   ID instruction reads rs1
// ID_UsesRs2    in   1   ID instruction reads rs2
// ID_IsStore    in   1   ID instruction is a store (rs2 = store data)
// ID_IsBranch   in   1   ID instruction is a branch/JALR resolved in ID
// branch_taken  in   1   ID branch ALU resolved taken/redirect
// EX_MemRead    in   1   EX instruction is a load
// EX_RegWrite   in   1   EX instruction writes Rd
// EX_Rd         in   5   EX destination register
// MEM_MemRead   in   1   MEM instruction is a load
// MEM_Rd        in   5   MEM destination register
// EX_DivStart   in   1   divide entered EX this cycle (1-cycle pulse)
// PC_stall      out  1   hold PC
// IFID_stall    out  1   hold IF/ID register
// IFID_flush    out  1   zero IF/ID (squash fetched instruction)
// IDEX_bubble   out  1   load NOP into ID/EX
// EX_stall      out  1   hold ID/EX and EX/MEM (divide in progress)
// div_busy      out  1   divide FSM active
// stall_cycles  out  STAT_WIDTH  front-end stall cycle count (HAZARD_STATS_EN only)
// BEHAVIOUR
// - match(r) = (r!=0) && ((ID_UsesRs1 && ID_Rs1==r) || (ID_UsesRs2 && ID_Rs2==r)).
// - Exception: match on rs2 only, with ID_IsStore and !ID_IsBranch, is not a load-use hazard.
//   The memory-stage WB forward covers it.
// - Hazard terms, evaluated combinationally in IDLE:
//   LU  = EX_MemRead && match(EX_Rd) && !ID_IsBranch                  -> 1 stall cycle
//   BR1 = ID_IsBranch && EX_RegWrite && !EX_MemRead && match(EX_Rd)   -> 1 stall cycle
//   BR2 = ID_IsBranch && EX_MemRead && match(EX_Rd)                   -> 2 stall cycles
//   BRM = ID_IsBranch && MEM_MemRead && match(MEM_Rd)                 -> 1 stall cycle
// - FSM states:
//   IDLE -> STALL2 when BR2 (first stall cycle is combinational in IDLE). STALL2 -> IDLE after one cycle.
//   In STALL2, front-end stall is forced regardless of the inputs.
// - Divide:
//   IDLE/STALL2 -> DIV when EX_DivStart. Load div_cnt = DIV_LATENCY-2.
//   EX_stall=1 and PC/IFID stall=1 from the cycle after EX_DivStart.
//   In DIV, decrement div_cnt; return to IDLE in the cycle after div_cnt reaches 0.
//   Total EX occupancy: DIV_LATENCY cycles.
//   div_busy = (state==DIV). IDEX_bubble=0 in DIV (ID/EX is held, not bubbled).
// - Front-end stall:
//   fs = DIV || STALL2 || LU || BR1 || BR2 || BRM.
//   PC_stall = IFID_stall = fs. IDEX_bubble = fs && !DIV.
// - Flush: IFID_flush = branch_taken && !fs. A stalled branch is unresolved; its taken result is ignored.
// - Priority: DIV overrides all hazards. EX_DivStart arriving while in STALL2 enters DIV; the remaining stall is subsumed.
// - All outputs combinational from state+inputs; zero latency to hazard inputs.
// - Reset (async, any state, including mid-divide):
//   state=IDLE, div_cnt=0, stall_cycles=0.
//   While rst=1, all outputs are forced 0.
// CONFIGURATION
// HAZARD_STATS_EN defined:
//   stall_cycles port exists; increments by 1 each clk with PC_stall=1; saturates at all-ones.
// HAZARD_STATS_EN undefined:
//   port absent; no counter logic. Remaining behaviour identical.
// TESTING
// T1 lw x5 in EX (EX_MemRead=1,EX_Rd=5), ID add uses rs1=x5 -> PC_stall=IFID_stall=IDEX_bubble=1 for 1 cycle, then 0.
// T2 lw x5 in EX, ID sw with rs2=x5 only, rs1=x2 -> no stall.
//    Same with rs1=x5 -> 1-cycle stall.
// T3 lw x7 in EX, ID beq rs1=x7 -> stall 2 cycles (combinational, then STALL2).
//    addi x7 in EX -> 1 cycle.
//    x0 as Rd anywhere -> no stall.
// T4 EX_DivStart pulse, DIV_LATENCY=8 -> EX_stall/div_busy high for 7 cycles starting next cycle.
//    Then IDLE; no IDEX_bubble during DIV.
// T5 branch_taken=1 with no hazard -> IFID_flush=1.
//    branch_taken=1 with BR1 active -> IFID_flush=0, stall=1.
// T6 assert rst mid-DIV (cnt=3) -> all outputs 0 immediately; after release, IDLE, div_busy=0.
//    With HAZARD_STATS_EN, stall_cycles=0; T1 then T3 -> stall_cycles=3.

Source files
------------

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: ID/EX/MEM hazard inputs and pipeline control outputs.
// stall_cycles exists only when HAZARD_STATS_EN is defined.
interface pipeline_hazard_controller_if #(
  parameter int unsigned STAT_WIDTH = 32
);
  logic [4:0] ID_Rs1;
  logic [4:0] ID_Rs2;
  logic       ID_UsesRs1;
  logic       ID_UsesRs2;
  logic       ID_IsStore;
  logic       ID_IsBranch;
  logic       branch_taken;
  logic       EX_MemRead;
  logic       EX_RegWrite;
  logic [4:0] EX_Rd;
  logic       MEM_MemRead;
  logic [4:0] MEM_Rd;
  logic       EX_DivStart;
  logic       PC_stall;
  logic       IFID_stall;
  logic       IFID_flush;
  logic       IDEX_bubble;
  logic       EX_stall;
  logic       div_busy;
`ifdef HAZARD_STATS_EN
  logic [STAT_WIDTH-1:0] stall_cycles;
`endif

  modport master (
    output ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, ID_IsStore, ID_IsBranch,
           branch_taken, EX_MemRead, EX_RegWrite, EX_Rd, MEM_MemRead, MEM_Rd,
           EX_DivStart,
`ifdef HAZARD_STATS_EN
    input  stall_cycles,
`endif
    input  PC_stall, IFID_stall, IFID_flush, IDEX_bubble, EX_stall, div_busy
  );

  modport slave (
    input  ID_Rs1, ID_Rs2, ID_UsesRs1, ID_UsesRs2, ID_IsStore, ID_IsBranch,
           branch_taken, EX_MemRead, EX_RegWrite, EX_Rd, MEM_MemRead, MEM_Rd,
           EX_DivStart,
`ifdef HAZARD_STATS_EN
    output stall_cycles,
`endif
    output PC_stall, IFID_stall, IFID_flush, IDEX_bubble, EX_stall, div_busy
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Decode-stage hazard/stall controller: load-use, in-flight branch operands, multi-cycle divide.
// Optional stall-cycle counter enabled by defining HAZARD_STATS_EN.
module pipeline_hazard_controller #(
  parameter int unsigned DIV_LATENCY = 8,
  parameter int unsigned STAT_WIDTH  = 32
) (
  input logic                          clk,
  input logic                          rst,
  pipeline_hazard_controller_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(DIV_LATENCY);

  typedef enum logic [1:0] {IDLE, STALL2, DIV} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   div_cnt, div_cnt_next;

  logic ex_nz, mem_nz;
  logic rs1_ex, rs2_ex, rs1_mem, rs2_mem;
  logic lu, br1, br2, brm;
  logic in_div, fs;

  // Operand match terms against the EX and MEM destinations
  assign ex_nz   = (bus.EX_Rd  != 5'd0);
  assign mem_nz  = (bus.MEM_Rd != 5'd0);
  assign rs1_ex  = bus.ID_UsesRs1 && (bus.ID_Rs1 == bus.EX_Rd);
  assign rs2_ex  = bus.ID_UsesRs2 && (bus.ID_Rs2 == bus.EX_Rd);
  assign rs1_mem = bus.ID_UsesRs1 && (bus.ID_Rs1 == bus.MEM_Rd);
  assign rs2_mem = bus.ID_UsesRs2 && (bus.ID_Rs2 == bus.MEM_Rd);

  // Store data on rs2 is forwarded late from MEM/WB, so it never waits on a load
  assign lu  = bus.EX_MemRead && ex_nz && !bus.ID_IsBranch &&
               (rs1_ex || (rs2_ex && !bus.ID_IsStore));
  assign br1 = bus.ID_IsBranch && bus.EX_RegWrite && !bus.EX_MemRead && ex_nz &&
               (rs1_ex || rs2_ex);
  assign br2 = bus.ID_IsBranch && bus.EX_MemRead && ex_nz && (rs1_ex || rs2_ex);
  assign brm = bus.ID_IsBranch && bus.MEM_MemRead && mem_nz && (rs1_mem || rs2_mem);

  assign in_div = (state == DIV);
  assign fs     = in_div || (state == STALL2) ||
                  ((state == IDLE) && (lu || br1 || br2 || brm));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      div_cnt <= '0;
    end else begin
      state   <= state_next;
      div_cnt <= div_cnt_next;
    end
  end

  // Next-state: divide start wins over any pending branch stall
  always_comb begin
    state_next   = state;
    div_cnt_next = div_cnt;
    unique case (state)
      IDLE: begin
        if (bus.EX_DivStart) begin
          state_next   = DIV;
          div_cnt_next = CNT_W'(DIV_LATENCY - 2);
        end else if (br2) begin
          state_next = STALL2;
        end
      end
      STALL2: begin
        if (bus.EX_DivStart) begin
          state_next   = DIV;
          div_cnt_next = CNT_W'(DIV_LATENCY - 2);
        end else begin
          state_next = IDLE;
        end
      end
      DIV: begin
        if (div_cnt == '0) state_next = IDLE;
        else               div_cnt_next = div_cnt - CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs, all held low during reset
  assign bus.PC_stall    = !rst && fs;
  assign bus.IFID_stall  = !rst && fs;
  assign bus.IDEX_bubble = !rst && fs && !in_div;
  assign bus.EX_stall    = !rst && in_div;
  assign bus.div_busy    = !rst && in_div;
  assign bus.IFID_flush  = !rst && bus.branch_taken && !fs;

`ifdef HAZARD_STATS_EN
  logic [STAT_WIDTH-1:0] stall_cnt;

  // Saturating count of front-end stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (bus.PC_stall && (stall_cnt != {STAT_WIDTH{1'b1}})) begin
      stall_cnt <= stall_cnt + STAT_WIDTH'(1);
    end
  end

  assign bus.stall_cycles = stall_cnt;
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed self-checking bench for pipeline_hazard_controller (DIV_LATENCY=8).
module tb_pipeline_hazard_controller;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_controller_if #(.STAT_WIDTH(32)) bus_if ();

  pipeline_hazard_controller #(.DIV_LATENCY(8), .STAT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // {PC_stall, IFID_stall, IDEX_bubble, EX_stall, div_busy, IFID_flush}
  logic [5:0] o;
  assign o = {bus_if.PC_stall, bus_if.IFID_stall, bus_if.IDEX_bubble,
              bus_if.EX_stall, bus_if.div_busy, bus_if.IFID_flush};

  localparam logic [5:0] NONE  = 6'b000000;
  localparam logic [5:0] STALL = 6'b111000;
  localparam logic [5:0] DIVO  = 6'b110110;
  localparam logic [5:0] FLUSH = 6'b000001;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus_if.ID_Rs1 = 5'd0;       bus_if.ID_Rs2 = 5'd0;
    bus_if.ID_UsesRs1 = 1'b0;   bus_if.ID_UsesRs2 = 1'b0;
    bus_if.ID_IsStore = 1'b0;   bus_if.ID_IsBranch = 1'b0;
    bus_if.branch_taken = 1'b0; bus_if.EX_MemRead = 1'b0;
    bus_if.EX_RegWrite = 1'b0;  bus_if.EX_Rd = 5'd0;
    bus_if.MEM_MemRead = 1'b0;  bus_if.MEM_Rd = 5'd0;
    bus_if.EX_DivStart = 1'b0;
  endtask

  // Advance one clock and leave time after the edge before driving new inputs
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    clr();
    // Hazard and branch inputs active during reset must not reach the outputs
    bus_if.EX_MemRead = 1'b1; bus_if.EX_Rd = 5'd5;
    bus_if.ID_UsesRs1 = 1'b1; bus_if.ID_Rs1 = 5'd5;
    bus_if.branch_taken = 1'b1;
    #1 chk("reset_outputs", 32'(o), 32'(NONE));
    cyc(); cyc();
    rst = 1'b0;
    clr();
    #1 chk("idle_after_reset", 32'(o), 32'(NONE));

    // T1 load-use on rs1
    cyc(); clr();
    bus_if.EX_MemRead = 1'b1; bus_if.EX_Rd = 5'd5;
    bus_if.ID_UsesRs1 = 1'b1; bus_if.ID_Rs1 = 5'd5;
    #1 chk("t1_lu_stall", 32'(o), 32'(STALL));
    cyc(); clr();
    bus_if.MEM_MemRead = 1'b1; bus_if.MEM_Rd = 5'd5;
    bus_if.ID_UsesRs1 = 1'b1; bus_if.ID_Rs1 = 5'd5;
    #1 chk("t1_released", 32'(o), 32'(NONE));

    // T2 store data on rs2 does not stall; store address on rs1 does
    cyc(); clr();
    bus_if.EX_MemRead = 1'b1; bus_if.EX_Rd = 5'd5;
    bus_if.ID_IsStore = 1'b1;
    bus_if.ID_UsesRs1 = 1'b1; bus_if.ID_Rs1 = 5'd2;
    bus_if.ID_UsesRs2 = 1'b1; bus_if.ID_Rs2 = 5'd5;
    #1 chk("t2_store_rs2", 32'(o), 32'(NONE));
    bus_if.ID_Rs1 = 5'd5;
    #1 chk("t2_store_rs1", 32'(o), 32'(STALL));

    // T3 load feeding a branch: two stall cycles, taken result suppressed
    cyc(); clr();
    bus_if.EX_MemRead = 1'b1; bus_if.EX_RegWrite = 1'b1; bus_if.EX_Rd = 5'd7;
    bus_if.ID_IsBranch = 1'b1; bus_if.ID_UsesRs1 = 1'b1; bus_if.ID_Rs1 = 5'd7;
    bus_if.branch_taken = 1'b1;
    #1 chk("t3_br2_first", 32'(o), 32'(STALL));
    cyc(); clr();
    bus_if.branch_taken = 1'b1;
    #1 chk("t3_br2_stall2", 32'(o), 32'(STALL));
    cyc(); clr();
    #1 chk("t3_br2_done", 32'(o), 32'(NONE));
    // T5 taken branch with no hazard flushes IF/ID
    bus_if.branch_taken = 1'b1;
    #1 chk("t5_flush", 32'(o), 32'(FLUSH));

    // T3 ALU result feeding a branch: one cycle; T5 flush masked by the stall
    cyc(); clr();
    bus_if.EX_RegWrite = 1'b1; bus_if.EX_Rd = 5'd7;
    bus_if.ID_IsBranch = 1'b1; bus_if.ID_UsesRs1 = 1'b1; bus_if.ID_Rs1 = 5'd7;
    bus_if.branch_taken = 1'b1;
    #1 chk("t5_br1_noflush", 32'(o), 32'(STALL));
    cyc(); clr();
    #1 chk("t3_br1_one_cycle", 32'(o), 32'(NONE));

    // Load in MEM feeding a branch via rs2
    bus_if.MEM_MemRead = 1'b1; bus_if.MEM_Rd = 5'd9;
    bus_if.ID_IsBranch = 1'b1; bus_if.ID_UsesRs2 = 1'b1; bus_if.ID_Rs2 = 5'd9;
    #1 chk("brm_stall", 32'(o), 32'(STALL));

    // x0 destinations never stall
    cyc(); clr();
    bus_if.EX_MemRead = 1'b1; bus_if.EX_RegWrite = 1'b1; bus_if.EX_Rd = 5'd0;
    bus_if.MEM_MemRead = 1'b1; bus_if.MEM_Rd = 5'd0;
    bus_if.ID_IsBranch = 1'b1; bus_if.ID_UsesRs1 = 1'b1; bus_if.ID_UsesRs2 = 1'b1;
    #1 chk("x0_branch", 32'(o), 32'(NONE));
    bus_if.ID_IsBranch = 1'b0;
    #1 chk("x0_lu", 32'(o), 32'(NONE));

    // T4 divide: seven DIV cycles after the start pulse, no bubbles, no flush
    cyc(); clr();
    bus_if.EX_DivStart = 1'b1;
    #1 chk("t4_div_start", 32'(o), 32'(NONE));
    for (int i = 0; i < 7; i++) begin
      cyc(); clr();
      bus_if.EX_MemRead = 1'b1; bus_if.EX_Rd = 5'd5;
      bus_if.ID_UsesRs1 = 1'b1; bus_if.ID_Rs1 = 5'd5;
      bus_if.branch_taken = 1'b1;
      #1 chk($sformatf("t4_div_cycle%0d", i), 32'(o), 32'(DIVO));
    end
    cyc(); clr();
    #1 chk("t4_div_done", 32'(o), 32'(NONE));

    // Divide starting during STALL2 takes over
    cyc(); clr();
    bus_if.EX_MemRead = 1'b1; bus_if.EX_Rd = 5'd3;
    bus_if.ID_IsBranch = 1'b1; bus_if.ID_UsesRs2 = 1'b1; bus_if.ID_Rs2 = 5'd3;
    cyc(); clr();
    bus_if.EX_DivStart = 1'b1;
    #1 chk("stall2_divstart", 32'(o), 32'(STALL));
    cyc(); clr();
    #1 chk("stall2_to_div", 32'(o), 32'(DIVO));
    for (int i = 0; i < 6; i++) cyc();
    #1 chk("stall2_div_last", 32'(o), 32'(DIVO));
    cyc();
    #1 chk("stall2_div_done", 32'(o), 32'(NONE));

    // T6 reset mid-divide at div_cnt=3
    cyc(); clr();
    bus_if.EX_DivStart = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); clr();
    end
    #1 chk("t6_mid_div", 32'(o), 32'(DIVO));
    rst = 1'b1;
    bus_if.branch_taken = 1'b1;
    #1 chk("t6_reset_forced", 32'(o), 32'(NONE));
    cyc();
    rst = 1'b0;
    clr();
    #1 chk("t6_after_release", 32'(o), 32'(NONE));
    cyc();
    #1 chk("t6_div_busy", 32'(bus_if.div_busy), 32'(0));
`ifdef HAZARD_STATS_EN
    chk("t6_stats_reset", bus_if.stall_cycles, 32'd0);
`endif

    // T1 then T3 after reset: 1 + 2 stall cycles
    clr();
    bus_if.EX_MemRead = 1'b1; bus_if.EX_Rd = 5'd5;
    bus_if.ID_UsesRs1 = 1'b1; bus_if.ID_Rs1 = 5'd5;
    #1 chk("t6_t1_stall", 32'(o), 32'(STALL));
    cyc(); clr();
    bus_if.EX_MemRead = 1'b1; bus_if.EX_Rd = 5'd7;
    bus_if.ID_IsBranch = 1'b1; bus_if.ID_UsesRs1 = 1'b1; bus_if.ID_Rs1 = 5'd7;
    #1 chk("t6_t3_first", 32'(o), 32'(STALL));
    cyc(); clr();
    #1 chk("t6_t3_stall2", 32'(o), 32'(STALL));
    cyc();
    #1 chk("t6_idle", 32'(o), 32'(NONE));
`ifdef HAZARD_STATS_EN
    chk("t6_stats_count", bus_if.stall_cycles, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
